controller_poller: RTL and testbench

Parametrised poll engine for the custom game controller: generates a periodic poll tick from the system clock, then runs one latch/clock serial read of a shift-register gamepad (SNES-style, active-low data). Each frame's buttons are presented as an active-high parallel word with a one-cycle valid strobe. Sits between the controller GPIO pins and the game logic, and replaces the bare 60 Hz tick counter.

---
 rtl/controller_poller_if.sv | 36 +++
 rtl/controller_poller.sv | 135 +++++++++++++
 tb/tb_controller_poller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_poller_if.sv
// Signal bundle between the poll engine, the controller GPIO pins and the game logic.
// The master side is the poll engine and the slave side is the pins plus the consumer.
interface controller_poller_if #(
  parameter int unsigned NUM_BITS = 16
);
  logic                enable;
  logic                ctrl_data;
  logic                ctrl_latch;
  logic                ctrl_clk;
  logic [NUM_BITS-1:0] buttons;
  logic                valid;
  logic                poll_tick;
  logic                overrun;

  modport master (
    input  enable,
    input  ctrl_data,
    output ctrl_latch,
    output ctrl_clk,
    output buttons,
    output valid,
    output poll_tick,
    output overrun
  );

  modport slave (
    output enable,
    output ctrl_data,
    input  ctrl_latch,
    input  ctrl_clk,
    input  buttons,
    input  valid,
    input  poll_tick,
    input  overrun
  );
endinterface

// File: rtl/controller_poller.sv
// Periodic poll tick plus one latch/clock serial read of an SNES-style gamepad per tick.
// Buttons are presented active high with a one-cycle valid strobe when a frame completes.
module controller_poller #(
  parameter int unsigned POLL_PERIOD = 833333,
  parameter int unsigned HALF_BIT    = 300,
  parameter int unsigned NUM_BITS    = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  controller_poller_if.master bus
);
  localparam int unsigned PW    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned TW    = $clog2(2 * HALF_BIT);
  localparam int unsigned IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [PW-1:0]    PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0]    LATCH_LAST  = TW'(2 * HALF_BIT - 1);
  localparam logic [TW-1:0]    HALF_LAST   = TW'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] BIT_LAST    = IDX_W'(NUM_BITS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LATCH    = 3'd1;
  localparam logic [2:0] S_CLK_LOW  = 3'd2;
  localparam logic [2:0] S_CLK_HIGH = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [PW-1:0]       period_cnt;
  logic                poll_tick_q;
  logic [2:0]          state;
  logic [TW-1:0]       timer;
  logic [IDX_W-1:0]    bit_idx;
  logic [NUM_BITS-1:0] shreg;
  logic [NUM_BITS-1:0] buttons_q;
  logic                latch_q;
  logic                clk_q;
  logic                valid_q;
  logic                overrun_q;

  // Tick generator: counts enabled cycles, held at zero while disabled.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_cnt  <= '0;
      poll_tick_q <= 1'b0;
    end else if (!bus.enable) begin
      period_cnt  <= '0;
      poll_tick_q <= 1'b0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt  <= '0;
      poll_tick_q <= 1'b1;
    end else begin
      period_cnt  <= period_cnt + 1'b1;
      poll_tick_q <= 1'b0;
    end
  end

  // Frame sequencer; pin levels are registered on the transitions into each phase.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= poll_tick_q && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (poll_tick_q) begin
            state   <= S_LATCH;
            latch_q <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
          end
        end
        S_LATCH: begin
          if (timer == LATCH_LAST) begin
            state   <= S_CLK_LOW;
            latch_q <= 1'b0;
            clk_q   <= 1'b0;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CLK_LOW: begin
          if (timer == HALF_LAST) begin
            shreg[bit_idx] <= ~bus.ctrl_data;
            state          <= S_CLK_HIGH;
            clk_q          <= 1'b1;
            timer          <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CLK_HIGH: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (bit_idx == BIT_LAST) begin
              state     <= S_DONE;
              buttons_q <= shreg;
              valid_q   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              state   <= S_CLK_LOW;
              clk_q   <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          latch_q <= 1'b0;
          clk_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.poll_tick  = poll_tick_q;
  assign bus.ctrl_latch = latch_q;
  assign bus.ctrl_clk   = clk_q;
  assign bus.buttons    = buttons_q;
  assign bus.valid      = valid_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller: timing table, hand-written corner sequences, and a
// randomized run checked every cycle against a frame-schedule reference model.
`timescale 1ns/1ps
module tb_controller_poller;
  localparam int P  = 100;
  localparam int H  = 2;
  localparam int N  = 4;
  localparam int F  = 2 * H * (N + 1) + 1;
  localparam int P2 = 15;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  controller_poller_if #(.NUM_BITS(N)) bus ();
  controller_poller_if #(.NUM_BITS(N)) bus2 ();

  controller_poller #(.POLL_PERIOD(P), .HALF_BIT(H), .NUM_BITS(N)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );
  controller_poller #(.POLL_PERIOD(P2), .HALF_BIT(H), .NUM_BITS(N)) dut2 (
    .clk(clk), .n_rst(n_rst), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: frame start cycle, dropped tick, counting epoch.
  bit         m_en_on    = 1'b0;
  int         m_en_epoch = 0;
  int         m_fs       = -1000;
  int         m_drop     = -1000;
  logic [3:0] m_word     = '0;
  logic [3:0] m_btn      = '0;

  // Gamepad model: parallel load while latched, shift on rising ctrl_clk.
  logic [3:0] pad_word     = '0;
  logic [3:0] pad_sr       = 4'hF;
  logic       pad_clk_prev = 1'b1;

  bit   rec2 = 1'b1;
  logic r2_tick [64];
  logic r2_latch[64];
  logic r2_ov   [64];
  logic r2_valid[64];

  typedef struct {
    logic [3:0] pad;
    int         at;
    logic       tick;
    logic       latch;
    logic       sclk;
    logic       valid;
    logic [3:0] btn;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d got=%0h exp=%0h", name, tag, got, exp);
    end
  endtask

  function automatic logic [8:0] pk();
    return {bus.poll_tick, bus.ctrl_latch, bus.ctrl_clk, bus.valid, bus.overrun, bus.buttons};
  endfunction

  task automatic model_check();
    logic [8:0] exp;
    bit tk, bz, la, lo, vl, ov;
    int d, e;
    if (!n_rst) begin
      exp    = 9'b0_0_1_0_0_0000;
      m_fs   = -1000;
      m_drop = -1000;
      m_btn  = '0;
    end else begin
      tk = m_en_on && (cyc > m_en_epoch) && (((cyc - m_en_epoch) % P) == 0);
      bz = (cyc > m_fs) && (cyc <= m_fs + F);
      d  = cyc - m_fs;
      e  = d - (2 * H + 1);
      la = (d >= 1) && (d <= 2 * H);
      lo = (e >= 0) && (e < 2 * H * N) && ((e % (2 * H)) < H);
      vl = (d == F);
      ov = (m_drop == cyc - 1);
      if (vl) m_btn = m_word;
      exp = {tk, la, !lo, vl, ov, m_btn};
      if (tk) begin
        if (bz) m_drop = cyc;
        else begin
          m_fs   = cyc;
          m_word = pad_word;
        end
      end
    end
    check("model", cyc, int'(pk()), int'(exp));
  endtask

  task automatic pad_update();
    if (bus.ctrl_latch) pad_sr = ~pad_word;
    else if (bus.ctrl_clk && !pad_clk_prev) pad_sr = {1'b1, pad_sr[3:1]};
    pad_clk_prev  = bus.ctrl_clk;
    bus.ctrl_data = pad_sr[0];
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model_check();
    pad_update();
    if (rec2 && n_rst && cyc >= 0 && cyc < 64) begin
      r2_tick[cyc]  = bus2.poll_tick;
      r2_latch[cyc] = bus2.ctrl_latch;
      r2_ov[cyc]    = bus2.overrun;
      r2_valid[cyc] = bus2.valid;
    end
  endtask

  task automatic set_enable(input logic v);
    bus.enable = v;
    m_en_on    = v;
    if (v) m_en_epoch = cyc;
  endtask

  task automatic pulse_reset(input int hold);
    n_rst = 1'b0;
    repeat (hold) step();
    n_rst      = 1'b1;
    cyc        = 0;
    m_en_epoch = 0;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic add_vec(input logic [3:0] pad, input int at, input logic tk, input logic la,
                         input logic ck, input logic vl, input logic [3:0] btn);
    vec_t v;
    v.pad = pad; v.at = at; v.tick = tk; v.latch = la; v.sclk = ck; v.valid = vl; v.btn = btn;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.enable     = 1'b1;
    bus.ctrl_data  = 1'b1;
    bus2.enable    = 1'b1;
    bus2.ctrl_data = 1'b1;
    m_en_on        = 1'b1;
    for (int i = 0; i < 64; i++) begin
      r2_tick[i] = 1'b0; r2_latch[i] = 1'b0; r2_ov[i] = 1'b0; r2_valid[i] = 1'b0;
    end

    //      pad      at   tick latch clk valid btn
    add_vec(4'b0000,   1, 0, 0, 1, 0, 4'b0000);
    add_vec(4'b0000,  99, 0, 0, 1, 0, 4'b0000);
    add_vec(4'b0000, 100, 1, 0, 1, 0, 4'b0000);
    add_vec(4'b0000, 101, 0, 1, 1, 0, 4'b0000);
    add_vec(4'b0000, 104, 0, 1, 1, 0, 4'b0000);
    add_vec(4'b0000, 105, 0, 0, 0, 0, 4'b0000);
    add_vec(4'b0000, 106, 0, 0, 0, 0, 4'b0000);
    add_vec(4'b0000, 107, 0, 0, 1, 0, 4'b0000);
    add_vec(4'b0000, 109, 0, 0, 0, 0, 4'b0000);
    add_vec(4'b0000, 118, 0, 0, 0, 0, 4'b0000);
    add_vec(4'b0000, 119, 0, 0, 1, 0, 4'b0000);
    add_vec(4'b0000, 120, 0, 0, 1, 0, 4'b0000);
    add_vec(4'b0000, 121, 0, 0, 1, 1, 4'b0000);
    add_vec(4'b0000, 122, 0, 0, 1, 0, 4'b0000);
    add_vec(4'b0000, 200, 1, 0, 1, 0, 4'b0000);
    add_vec(4'b0000, 201, 0, 1, 1, 0, 4'b0000);
    add_vec(4'b1001, 100, 1, 0, 1, 0, 4'b0000);
    add_vec(4'b1001, 120, 0, 0, 1, 0, 4'b0000);
    add_vec(4'b1001, 121, 0, 0, 1, 1, 4'b1001);
    add_vec(4'b1001, 122, 0, 0, 1, 0, 4'b1001);
    add_vec(4'b1001, 150, 0, 0, 1, 0, 4'b1001);
    add_vec(4'b1001, 200, 1, 0, 1, 0, 4'b1001);
    add_vec(4'b1001, 221, 0, 0, 1, 1, 4'b1001);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].pad != vecs[i-1].pad) begin
        pad_word = vecs[i].pad;
        pulse_reset(3);
        check("reset_state", i, int'(pk()), int'(9'b0_0_1_0_0_0000));
        if (i != 0) rec2 = 1'b0;
      end
      run_to(vecs[i].at);
      check("vec", vecs[i].at, int'(pk()),
            int'({vecs[i].tick, vecs[i].latch, vecs[i].sclk, vecs[i].valid, 1'b0, vecs[i].btn}));
    end

    // Short-period instance recorded during the first run: dropped tick and overrun.
    check("p15_tick15", 15, int'(r2_tick[15]), 1);
    check("p15_latch16", 16, int'(r2_latch[16]), 1);
    check("p15_tick30", 30, int'(r2_tick[30]), 1);
    check("p15_ov30", 30, int'(r2_ov[30]), 0);
    check("p15_ov31", 31, int'(r2_ov[31]), 1);
    check("p15_ov32", 32, int'(r2_ov[32]), 0);
    check("p15_latch31", 31, int'(r2_latch[31]), 0);
    check("p15_valid35", 35, int'(r2_valid[35]), 0);
    check("p15_valid36", 36, int'(r2_valid[36]), 1);
    check("p15_tick45", 45, int'(r2_tick[45]), 1);
    check("p15_latch46", 46, int'(r2_latch[46]), 1);
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(r2_valid[i]);
    check("p15_valid_count", 63, n, 1);

    // Enable dropped mid-frame: frame completes, ticks stop until re-enabled.
    pad_word = 4'b0110;
    pulse_reset(3);
    run_to(109);
    set_enable(1'b0);
    run_to(121);
    check("en_drop_valid", 121, int'(bus.valid), 1);
    check("en_drop_btn", 121, int'(bus.buttons), 4'b0110);
    n = 0;
    while (cyc < 260) begin
      step();
      n += int'(bus.poll_tick);
    end
    check("en_drop_ticks", 260, n, 0);
    set_enable(1'b1);
    run_to(359);
    check("en_rise_tick99", 359, int'(bus.poll_tick), 0);
    run_to(360);
    check("en_rise_tick100", 360, int'(bus.poll_tick), 1);

    // Asynchronous reset during CLK_LOW of the second frame.
    pad_word = 4'b1001;
    pulse_reset(3);
    run_to(213);
    check("pre_rst_clk", 213, int'(bus.ctrl_clk), 0);
    check("pre_rst_btn", 213, int'(bus.buttons), 4'b1001);
    n_rst = 1'b0;
    #1;
    check("async_rst", 213, int'(pk()), int'(9'b0_0_1_0_0_0000));
    pulse_reset(2);
    n = 0;
    while (cyc < 99) begin
      step();
      n += int'(bus.valid) + int'(bus.poll_tick);
    end
    check("post_rst_quiet", 99, n, 0);
    run_to(100);
    check("post_rst_tick", 100, int'(bus.poll_tick), 1);

    // Randomized run: random pad words, enable gaps and occasional resets.
    pulse_reset(2);
    for (int i = 0; i < 5000; i++) begin
      step();
      if (bus.valid) pad_word = 4'($urandom);
      if (bus.enable ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 39) == 0))
        set_enable(!bus.enable);
      if ($urandom_range(0, 1999) == 0) pulse_reset(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
